display_page_scheduler: RTL and testbench
=========================================

# display_page_scheduler

Shares the 8-digit seven-segment display between up to 16 value sources, such as the debounced and noisy press counters and future counters. A round-robin, dwell-timed scheduler grants the display to one requesting source at a time. It formats that source's 16-bit value into the six-bit digit fields consumed by `sseg_driver` inputs I0..I7. A debounced-button tick forces an early advance; a hold input freezes automatic rotation.

## Interface
- `NUM_SRC`, 4: number of sources; legal range 2..16.
- `DWELL_CYCLES`, 100_000_000: clock cycles a page stays displayed; minimum 1.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_SRC  level; bit i high means source i has a value to display.
- `src_data`  in  16*NUM_SRC  four hex nibbles per source; source i occupies bits [16i+15:16i].
- `next_tick`  in  1  single-cycle pulse (debounced positive edge) forcing an advance.
- `hold`  in  1  level; suppresses dwell-expiry advance.
- `grant`  out  NUM_SRC  one-hot source currently displayed; zero when idle.
- `page_valid`  out  1  high while a source is granted.
- `digits`  out  48  eight 6-bit fields; field k, bits [6k+5:6k], drives I_k.
  - Field format: bit5 enable, bits4:1 hex value, bit0 decimal point (1 = lit).

## Operation
- States:
  - IDLE: nothing granted, all digits blank.
  - SHOW: a source is granted; the dwell counter runs.
  - SWITCH: one cycle in which the round-robin pick is made.
- IDLE -> SWITCH when `|req`.
- SHOW -> SWITCH when any of the following holds:
  - dwell count reaches DWELL_CYCLES-1 and `hold`=0;
  - `next_tick`=1;
  - `req` of the granted source is low.
- SWITCH -> SHOW when any source requests, else SWITCH -> IDLE.
- Round-robin pick: first requesting index searching from last_grant+1 upward, wrapping modulo NUM_SRC.
  - If only the current source requests, it is re-granted and the dwell counter restarts.
- Dwell counter is $clog2(DWELL_CYCLES)+1 bits wide.
  - Cleared on entering SHOW; increments each SHOW cycle; saturates while `hold`=1.
- Digit mapping while in SHOW:
  - digits 3..0 = granted nibbles 3..0, all enabled, dp off;
  - digit 7 = granted index in hex, enabled, dp lit when `hold`=1;
  - digits 6..4 = 6'b0 (blank).
- In IDLE and SWITCH, digits retain their previous value, except that IDLE forces all 48 bits to 0.
- `next_tick` coinciding with dwell expiry, or with the granted source dropping `req`, produces exactly one advance.
- `next_tick` in IDLE or SWITCH is ignored.
- `hold` does not block `next_tick` or req-drop advances.

## Timing
- Reset values:
  - state = IDLE;
  - `grant` = 0, `page_valid` = 0, `digits` = 0;
  - dwell counter = 0;
  - last_grant = NUM_SRC-1, so the first pick after reset is source 0 if it requests.
- All outputs are registered.
- Trigger sampled in cycle n, state SHOW: state = SWITCH at n+1; new `grant`/`page_valid` at n+2; new digits at n+3.
- `src_data` changes of the granted source appear on `digits` one cycle later (registered live refresh every SHOW cycle).
- From reset release with `req` already high, the first `grant` appears 2 cycles after the first sampling edge.
- Page period with no interruptions: DWELL_CYCLES + 1 cycles (SHOW plus SWITCH).
- Asserting `reset_n` low mid-page immediately returns all state and outputs to their reset values.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - digits 3..1 that are zero and above the most significant nonzero nibble have the enable bit cleared;
  - digit 0 is always enabled.
- `LEADING_ZERO_BLANK_EN` undefined: all four value digits are always enabled.
- State machine and timing are identical in both builds.

## Structure
- Package `display_pkg`:
  - `DIGIT_W` = 6;
  - `DIGIT_BLANK` = 6'b0;
  - digit field bit-position constants;
  - state enum (IDLE, SHOW, SWITCH).
- Sub-module `rr_picker` (combinational):
  - inputs `req` and `last_grant` index;
  - outputs one-hot next grant plus a found flag.
- The FSM, dwell counter and digit formatter live in the top module.

## Test plan
Common setup: NUM_SRC=4, DWELL_CYCLES=8.
- Reset with `req`=0: `grant`=0, `page_valid`=0, `digits`=0 throughout; all req bits held low for 50 cycles.
- `req`=4'b1011 held, no ticks: grant sequence 0001 -> 0010 -> 1000 -> 0001, each grant lasting 9 cycles.
- Source 1 data 16'h0A3F granted with `LEADING_ZERO_BLANK_EN` defined: digit3 blank, digits 2..0 show A,3,F, digit7 shows 1. Without the macro, digit3 shows 0 enabled.
- `hold`=1 for 40 cycles, then a `next_tick` pulse:
  - no rotation during the hold;
  - digit7 dp lit;
  - `grant` advances 2 cycles after the tick.
- Granted source 2 drops `req` while `next_tick` fires in the same cycle: exactly one advance to source 3, with no skip.
- Only source 0 requesting at dwell expiry: `grant` stays 0001, `page_valid` stays 1, dwell restarts. `reset_n` pulsed low mid-page: outputs go to 0 immediately.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and digit-field constants for the display page scheduler.
package display_pkg;

   localparam int         DIGIT_W     = 6;
   localparam logic [5:0] DIGIT_BLANK = 6'b0;
   localparam int         DIG_EN_BIT  = 5;
   localparam int         DIG_VAL_LSB = 1;
   localparam int         DIG_DP_BIT  = 0;
   localparam int         IDX_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      SWITCH
   } state_e;

   function automatic logic [IDX_W-1:0] oh2idx(input logic [15:0] oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/display_page_scheduler_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant,
// wrapping modulo NUM_SRC.
module rr_picker
   import display_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_SRC-1:0] grant,
   output logic               found
);

   logic [15:0]      req_w;
   logic [15:0]      gnt_w;
   logic [IDX_W-1:0] j;

   always_comb begin
      req_w = 16'(req);
      gnt_w = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         j = IDX_W'((int'(last_grant) + k) % NUM_SRC);
         if (!found && req_w[j]) begin
            gnt_w[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign grant = gnt_w[NUM_SRC-1:0];

endmodule

// File: rtl/display_page_scheduler.sv
// Dwell-timed round-robin sharing of the 8-digit display between sources.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_page_scheduler
   import display_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 100_000_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_SRC-1:0]    req,
   input  logic [16*NUM_SRC-1:0] src_data,
   input  logic                  next_tick,
   input  logic                  hold,
   output logic [NUM_SRC-1:0]    grant,
   output logic                  page_valid,
   output logic [47:0]           digits
);

   localparam int               CNT_W    = $clog2(DWELL_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic               pv_q, pv_d;
   logic [47:0]        digits_q, digits_d;

   logic [NUM_SRC-1:0] pick_oh;
   logic               pick_found;
   logic [255:0]       data_pad;
   logic [15:0]        cur;
   logic [3:0]         en;
   logic [47:0]        fmt;
   logic               expire;
   logic               adv;

   rr_picker #(.NUM_SRC(NUM_SRC)) u_pick (
      .req        (req),
      .last_grant (last_q),
      .grant      (pick_oh),
      .found      (pick_found)
   );

   assign data_pad = 256'(src_data);
   assign cur      = data_pad[{last_q, 4'b0000} +: 16];

   // Enable mask for value digits 3..0; digit 0 is never blanked.
`ifdef LEADING_ZERO_BLANK_EN
   assign en = {|cur[15:12], |cur[15:8], |cur[15:4], 1'b1};
`else
   assign en = 4'hF;
`endif

   always_comb begin
      fmt = '0;
      for (int k = 0; k < 4; k++) begin
         fmt[k*DIGIT_W +: DIGIT_W] = {en[k], cur[4*k +: 4], 1'b0};
      end
      fmt[7*DIGIT_W +: DIGIT_W] = {1'b1, last_q, hold};
   end

   assign expire = (cnt_q == CNT_LAST);
   assign adv    = (expire && !hold) || next_tick || !(|(req & grant_q));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      grant_d  = grant_q;
      pv_d     = pv_q;
      digits_d = digits_q;
      unique case (state_q)
         IDLE: begin
            grant_d  = '0;
            pv_d     = 1'b0;
            digits_d = '0;
            if (|req) state_d = SWITCH;
         end
         SHOW: begin
            digits_d = fmt;
            if (adv) begin
               state_d = SWITCH;
            end else if (!(hold && expire)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWITCH: begin
            cnt_d = '0;
            if (pick_found) begin
               state_d = SHOW;
               grant_d = pick_oh;
               pv_d    = 1'b1;
               last_d  = oh2idx(16'(pick_oh));
            end else begin
               state_d  = IDLE;
               grant_d  = '0;
               pv_d     = 1'b0;
               digits_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= IDX_W'(NUM_SRC - 1);
         grant_q  <= '0;
         pv_q     <= 1'b0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         pv_q     <= pv_d;
         digits_q <= digits_d;
      end
   end

   assign grant      = grant_q;
   assign page_valid = pv_q;
   assign digits     = digits_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Bench for display_page_scheduler: page-level model plus directed checks.
module tb_display_page_scheduler;

   localparam int NS = 4;
   localparam int DW = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [63:0] src_data = '0;
   logic        next_tick = 1'b0;
   logic        hold = 1'b0;
   logic [3:0]  grant;
   logic        page_valid;
   logic [47:0] digits;

   always #5 clk = ~clk;

   display_page_scheduler #(.NUM_SRC(NS), .DWELL_CYCLES(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .src_data   (src_data),
      .next_tick  (next_tick),
      .hold       (hold),
      .grant      (grant),
      .page_valid (page_valid),
      .digits     (digits)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Page formatting straight from the display rules.
   function automatic logic [47:0] fmt(int idx, logic [15:0] v, logic h);
      logic [47:0] r;
      logic        e;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         e = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
         e = (k == 0) || ((v >> (4 * k)) != 16'h0);
`endif
         r[6*k +: 6] = {e, v[4*k +: 4], 1'b0};
      end
      r[47:42] = {1'b1, 4'(idx), h};
      return r;
   endfunction

   // Model: mode 0 idle, 1 showing page m_cur for m_age cycles, 2 picking.
   int          m_mode, m_cur, m_last, m_age;
   logic [47:0] m_dig;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = 0; m_cur = -1; m_last = NS - 1; m_age = 0; m_dig = '0;
      end else begin
         case (m_mode)
            0: begin
               m_dig = '0;
               if (req != 4'b0) m_mode = 2;
            end
            1: begin
               m_dig = fmt(m_cur, src_data[16*m_cur +: 16], hold);
               if ((m_age >= DW - 1 && !hold) || next_tick || !req[m_cur])
                  m_mode = 2;
               else if (m_age < DW - 1)
                  m_age++;
            end
            default: begin
               int s;
               bit hit;
               hit = 1'b0;
               for (int k = 1; k <= NS; k++) begin
                  s = (m_last + k) % NS;
                  if (!hit && req[s]) begin hit = 1'b1; m_cur = s; end
               end
               if (hit) begin
                  m_last = m_cur; m_age = 0; m_mode = 1;
               end else begin
                  m_cur = -1; m_mode = 0; m_dig = '0;
               end
            end
         endcase
      end
   end

   bit mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("grant", 64'(grant), (m_cur < 0) ? 64'h0 : 64'(1 << m_cur));
         chk("page_valid", 64'(page_valid), 64'(m_cur >= 0));
         chk("digits", 64'(digits), 64'(m_dig));
      end
   end

   task automatic wait_grant(input logic [3:0] g, input string nm);
      int i;
      i = 0;
      @(negedge clk);
      while (grant !== g && i < 60) begin
         @(negedge clk);
         i++;
      end
      chk(nm, 64'(grant), 64'(g));
   endtask

   task automatic run_len(input logic [3:0] g, output int len);
      len = 0;
      while (grant === g && len < 100) begin
         len++;
         @(negedge clk);
      end
   endtask

   logic [3:0]  seqg [4];
   logic [47:0] exp_a3f;
   logic [5:0]  d3;
   int          len;

   initial begin
      seqg[0] = 4'b0001; seqg[1] = 4'b0010;
      seqg[2] = 4'b1000; seqg[3] = 4'b0001;
`ifdef LEADING_ZERO_BLANK_EN
      d3 = 6'h00;
`else
      d3 = 6'h20;
`endif
      exp_a3f = {6'h22, 6'h00, 6'h00, 6'h00, d3, 6'h34, 6'h26, 6'h3E};
      src_data = {16'h0005, 16'h00B0, 16'h0A3F, 16'h1234};

      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 reset_n = 1'b1;

      repeat (50) @(negedge clk);
      chk("idle_grant", 64'(grant), 64'h0);
      chk("idle_pv", 64'(page_valid), 64'h0);
      chk("idle_digits", 64'(digits), 64'h0);

      @(posedge clk);
      #1 req = 4'b1011;
      wait_grant(4'b0001, "first_grant");
      for (int i = 0; i < 3; i++) begin
         run_len(seqg[i], len);
         chk("dwell_len", 64'(len), 64'd9);
         chk("rr_next", 64'(grant), 64'(seqg[i+1]));
      end

      wait_grant(4'b0010, "src1_grant");
      @(negedge clk);
      chk("digits_0a3f", 64'(digits), 64'(exp_a3f));
      chk("model_pin", 64'(m_dig), 64'(exp_a3f));

      @(posedge clk);
      #1 hold = 1'b1;
      repeat (40) @(negedge clk);
      chk("hold_grant", 64'(grant), 64'h2);
      chk("hold_dp", 64'(digits[42]), 64'h1);
      @(posedge clk);
      #1 next_tick = 1'b1;
      @(posedge clk);
      #1 next_tick = 1'b0;
      @(negedge clk);
      chk("tick_wait", 64'(grant), 64'h2);
      @(negedge clk);
      chk("tick_adv", 64'(grant), 64'h8);
      @(posedge clk);
      #1 hold = 1'b0;

      @(posedge clk);
      #1 req = 4'b1111;
      wait_grant(4'b0100, "src2_grant");
      @(posedge clk);
      #1 begin req = 4'b1011; next_tick = 1'b1; end
      @(posedge clk);
      #1 next_tick = 1'b0;
      @(negedge clk);
      chk("drop_wait", 64'(grant), 64'h4);
      @(negedge clk);
      chk("drop_adv", 64'(grant), 64'h8);
      run_len(4'b1000, len);
      chk("drop_len", 64'(len), 64'd9);
      chk("drop_next", 64'(grant), 64'h1);

      @(posedge clk);
      #1 req = 4'b0001;
      wait_grant(4'b0001, "solo_grant0");
      repeat (30) begin
         @(negedge clk);
         chk("solo_grant", 64'(grant), 64'h1);
         chk("solo_pv", 64'(page_valid), 64'h1);
      end

      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_pv", 64'(page_valid), 64'h0);
      chk("rst_digits", 64'(digits), 64'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_grant(4'b0001, "post_rst_grant");

      @(posedge clk);
      #1 req = 4'b0000;
      repeat (6) @(negedge clk);
      chk("end_grant", 64'(grant), 64'h0);
      chk("end_digits", 64'(digits), 64'h0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
